// File: rtl/adder8_share_seq_if.sv
// Request/response bundle between the requesters and the shared-adder sequencer.
interface adder8_share_seq_if #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned NBYTES = 4
) ();
  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned W   = 8 * NBYTES;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;

  // Requester side
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/adder8_share_seq.sv
// Round-robin sequencer that time-shares one external 8-bit adder among NREQ
// requesters. Each byte k>=1 takes two adder passes (A+B, then +carry) so the
// adder is used verbatim, exact or approximate.
module adder8_share_seq #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned NBYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  adder8_share_seq_if.slave    bus,
  output logic [7:0]           add_in1,
  output logic [7:0]           add_in2,
  input  logic [8:0]           add_res,
  output logic                 add_en,
  output logic                 busy
);
  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned W   = 8 * NBYTES;
  localparam int unsigned KW  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StPassAb = 2'd1;
  localparam logic [1:0] StPassC  = 2'd2;
  localparam logic [1:0] StResp   = 2'd3;

  logic [1:0]     st_q, st_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IDW-1:0] id_q, id_d;
  logic [KW-1:0]  k_q, k_d;
  logic           carry_q, carry_d;
  logic [7:0]     p_q, p_d;
  logic           c1_q, c1_d;

  logic           grant_vld;
  logic [IDW-1:0] grant_idx;
  logic [W-1:0]   a_sel, b_sel;

  // Round-robin search starting at the pointer
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr_q) + i) % NREQ;
      if (!grant_vld && bus.req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
  end

  // Operand mux for the granted requester
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        a_sel = bus.req_a[i*W +: W];
        b_sel = bus.req_b[i*W +: W];
      end
    end
  end

  // Next-state, adder drive and grant
  always_comb begin
    st_d          = st_q;
    ptr_d         = ptr_q;
    a_d           = a_q;
    b_d           = b_q;
    sum_d         = sum_q;
    id_d          = id_q;
    k_d           = k_q;
    carry_d       = carry_q;
    p_d           = p_q;
    c1_d          = c1_q;
    bus.req_ready = '0;
    add_in1       = 8'h00;
    add_in2       = 8'h00;
    add_en        = 1'b0;
    case (st_q)
      StIdle: begin
        // Gated by rst_n so no grant is visible while reset is held
        if (grant_vld && rst_n) begin
          bus.req_ready[grant_idx] = 1'b1;
          a_d     = a_sel;
          b_d     = b_sel;
          id_d    = grant_idx;
          k_d     = '0;
          carry_d = 1'b0;
          ptr_d   = IDW'((32'(grant_idx) + 1) % NREQ);
          st_d    = StPassAb;
        end
      end
      StPassAb: begin
        add_in1 = a_q[{k_q, 3'b000} +: 8];
        add_in2 = b_q[{k_q, 3'b000} +: 8];
        add_en  = 1'b1;
        p_d     = add_res[7:0];
        c1_d    = add_res[8];
        if (k_q == '0) begin
          // Byte 0 has no incoming carry, so it needs no second pass
          sum_d[7:0] = add_res[7:0];
          carry_d    = add_res[8];
          if (NBYTES == 1) begin
            st_d = StResp;
          end else begin
            k_d = KW'(1);
          end
        end else begin
          st_d = StPassC;
        end
      end
      StPassC: begin
        add_in1 = p_q;
        add_in2 = {7'b0, carry_q};
        add_en  = 1'b1;
        sum_d[{k_q, 3'b000} +: 8] = add_res[7:0];
        carry_d = c1_q | add_res[8];
        if (k_q == KW'(NBYTES - 1)) begin
          st_d = StResp;
        end else begin
          k_d  = k_q + KW'(1);
          st_d = StPassAb;
        end
      end
      StResp: begin
        if (bus.rsp_ready) st_d = StIdle;
      end
      default: st_d = StIdle;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= StIdle;
      ptr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      id_q    <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      p_q     <= 8'h00;
      c1_q    <= 1'b0;
    end else begin
      st_q    <= st_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      p_q     <= p_d;
      c1_q    <= c1_d;
    end
  end

  // Response fields are only driven while the result is presented
  always_comb begin
    bus.rsp_valid = (st_q == StResp);
    bus.rsp_id    = bus.rsp_valid ? id_q : '0;
    bus.rsp_sum   = bus.rsp_valid ? sum_q : '0;
    bus.rsp_cout  = bus.rsp_valid & carry_q;
    busy          = (st_q != StIdle);
  end
endmodule

// File: tb/tb_adder8_share_seq.sv
// Directed bench for adder8_share_seq: default 4x4-byte instance plus a
// single-byte instance, each paired with an exact 8-bit adder.
module tb_adder8_share_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adder8_share_seq_if #(.NREQ(4), .NBYTES(4)) bus0 ();
  adder8_share_seq_if #(.NREQ(4), .NBYTES(1)) bus1 ();

  logic [7:0] add_in1_0, add_in2_0, add_in1_1, add_in2_1;
  logic [8:0] add_res_0, add_res_1;
  logic       add_en_0, add_en_1, busy_0, busy_1;

  assign add_res_0 = {1'b0, add_in1_0} + {1'b0, add_in2_0};
  assign add_res_1 = {1'b0, add_in1_1} + {1'b0, add_in2_1};

  adder8_share_seq #(.NREQ(4), .NBYTES(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .add_in1(add_in1_0), .add_in2(add_in2_0), .add_res(add_res_0),
    .add_en(add_en_0), .busy(busy_0)
  );

  adder8_share_seq #(.NREQ(4), .NBYTES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .add_in1(add_in1_1), .add_in2(add_in2_1), .add_res(add_res_1),
    .add_en(add_en_1), .busy(busy_1)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called in the first cycle after accept; returns in the RESP cycle.
  task automatic wait_rsp(input string tag, input int exp_lat, input logic [31:0] exp_sum,
                          input logic exp_cout, input logic [1:0] exp_id);
    int n;
    int en;
    n  = 1;
    en = 0;
    while (!bus0.rsp_valid && n < 20) begin
      if (add_en_0) en++;
      tick;
      n++;
    end
    chk({tag, "_lat"},  64'(n), 64'(exp_lat));
    chk({tag, "_en"},   64'(en), 64'(exp_lat - 1));
    chk({tag, "_sum"},  bus0.rsp_sum, exp_sum);
    chk({tag, "_cout"}, bus0.rsp_cout, exp_cout);
    chk({tag, "_id"},   bus0.rsp_id, exp_id);
  endtask

  task automatic start(input int r, input logic [31:0] a, input logic [31:0] b);
    bus0.req_a[r*32 +: 32] = a;
    bus0.req_b[r*32 +: 32] = b;
    bus0.req_valid[r]      = 1'b1;
    #1;
  endtask

  task automatic op(input string tag, input int r, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp_sum, input logic exp_cout);
    logic [3:0] one;
    one = 4'b0001;
    start(r, a, b);
    chk({tag, "_ready"}, bus0.req_ready, 64'(one << r));
    tick;
    bus0.req_valid[r] = 1'b0;
    wait_rsp(tag, 8, exp_sum, exp_cout, 2'(r));
    tick;
    chk({tag, "_idle"}, busy_0, 1'b0);
  endtask

  logic [31:0] tbl_a   [4] = '{32'h00000001, 32'h000000FF, 32'hFFFF0000, 32'h7FFFFFFF};
  logic [31:0] tbl_b   [4] = '{32'h00000002, 32'h00000001, 32'h00010000, 32'h7FFFFFFF};
  logic [31:0] tbl_sum [4] = '{32'h00000003, 32'h00000100, 32'h00000000, 32'hFFFFFFFE};
  logic        tbl_cout[4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int en;
    int seen;
    int w;
    logic [3:0] one;
    one = 4'b0001;
    rst_n          = 1'b0;
    bus0.req_valid = '0;
    bus0.req_a     = '0;
    bus0.req_b     = '0;
    bus0.rsp_ready = 1'b1;
    bus1.req_valid = '0;
    bus1.req_a     = '0;
    bus1.req_b     = '0;
    bus1.rsp_ready = 1'b1;
    tick;
    tick;
    chk("rst_rsp_valid", bus0.rsp_valid, 1'b0);
    chk("rst_busy",      busy_0, 1'b0);
    chk("rst_add_en",    add_en_0, 1'b0);
    chk("rst_add_in",    {add_in1_0, add_in2_0}, 16'h0000);
    chk("rst_sum",       bus0.rsp_sum, 32'h0);
    chk("rst_ready",     bus0.req_ready, 4'b0000);
    rst_n = 1'b1;
    tick;

    // Single-byte instance: FF+01
    bus1.req_a[7:0]   = 8'hFF;
    bus1.req_b[7:0]   = 8'h01;
    bus1.req_valid[0] = 1'b1;
    #1;
    chk("b1_ready", bus1.req_ready, 4'b0001);
    tick;
    bus1.req_valid[0] = 1'b0;
    n  = 1;
    en = 0;
    while (!bus1.rsp_valid && n < 20) begin
      if (add_en_1) en++;
      tick;
      n++;
    end
    chk("b1_lat",  64'(n), 64'd2);
    chk("b1_en",   64'(en), 64'd1);
    chk("b1_sum",  bus1.rsp_sum, 8'h00);
    chk("b1_cout", bus1.rsp_cout, 1'b1);
    chk("b1_id",   bus1.rsp_id, 2'd0);
    tick;
    chk("b1_idle", busy_1, 1'b0);

    op("t1", 0, 32'h12345678, 32'h0F0F0F0F, 32'h21436587, 1'b0);
    op("t2", 2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1);
    op("t2b", 3, 32'h00FF00FF, 32'h00010001, 32'h01000100, 1'b0);
    op("t2c", 1, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1);

    // Response back-pressure, with another request waiting
    bus0.rsp_ready = 1'b0;
    start(0, 32'hDEADBEEF, 32'h11111111);
    chk("t4_ready", bus0.req_ready, 4'b0001);
    tick;
    bus0.req_valid = 4'b0000;
    start(3, 32'h00FF00FF, 32'h00010001);
    wait_rsp("t4", 8, 32'hEFBED000, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("t4_hold_valid", bus0.rsp_valid, 1'b1);
      chk("t4_hold_sum",   bus0.rsp_sum, 32'hEFBED000);
      chk("t4_hold_ready", bus0.req_ready, 4'b0000);
    end
    bus0.rsp_ready = 1'b1;
    tick;
    chk("t4_rel_ready", bus0.req_ready, 4'b1000);
    tick;
    bus0.req_valid = 4'b0000;
    wait_rsp("t4b", 8, 32'h01000100, 1'b0, 2'd3);
    tick;

    // Reset in the middle of an operation
    start(1, 32'h12345678, 32'h0F0F0F0F);
    tick;
    bus0.req_valid = 4'b0000;
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    chk("t5_busy",   busy_0, 1'b0);
    chk("t5_add_en", add_en_0, 1'b0);
    chk("t5_add_in", {add_in1_0, add_in2_0}, 16'h0000);
    chk("t5_valid",  bus0.rsp_valid, 1'b0);
    tick;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (bus0.rsp_valid) seen++;
    end
    chk("t5_no_rsp", 64'(seen), 64'd0);

    // All requesters valid continuously: grant order 0,1,2,3,0
    for (int i = 0; i < 4; i++) begin
      bus0.req_a[i*32 +: 32] = tbl_a[i];
      bus0.req_b[i*32 +: 32] = tbl_b[i];
    end
    bus0.req_valid = 4'b1111;
    #1;
    for (int j = 0; j < 5; j++) begin
      w = 0;
      while (bus0.req_ready == 4'b0000 && w < 20) begin
        tick;
        w++;
      end
      chk("t3_grant", bus0.req_ready, 64'(one << (j % 4)));
      tick;
      wait_rsp("t3", 8, tbl_sum[j % 4], tbl_cout[j % 4], 2'(j % 4));
      chk("t3_busy_ready", bus0.req_ready, 4'b0000);
      tick;
    end
    bus0.req_valid = 4'b0000;
    tick;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
